// File: rtl/mult_share_arb_if.sv
// mult_share_arb_if
// Requester-side bus of the shared-multiplier scheduler.
//   req_valid  per-requester operand-pair valid
//   req_ready  one-hot grant from the scheduler
//   req_a/b    packed operands, requester i at [i*DW +: DW]
//   req_mask   1 = requester excluded from arbitration
//   rsp_valid  one-hot, single-cycle response strobe
//   rsp_data   registered product belonging to the strobed requester
// Modports: master = requester side, slave = scheduler side.
interface mult_share_arb_if #(
  parameter int DW   = 1,
  parameter int NREQ = 4
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*DW-1:0] req_a;
  logic [NREQ*DW-1:0] req_b;
  logic [NREQ-1:0]    req_mask;
  logic [NREQ-1:0]    rsp_valid;
  logic [2*DW-1:0]    rsp_data;

  modport master (
    output req_valid, req_a, req_b, req_mask,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_a, req_b, req_mask,
    output req_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/mult_share_arb.sv
// mult_share_arb
// Round-robin scheduler sharing one fully pipelined multiplier between NREQ
// requesters. One operand pair is accepted per cycle, registered into the
// multiplier, and the issuing index rides a tag pipeline so the product can
// be returned with a one-hot response strobe MUL_LAT+1 clocks later.
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   bus (slave)     requester handshake, mask and response signals
//   mul_i0, mul_i1  registered operands to the multiplier
//   mul_out         multiplier product (valid MUL_LAT edges after operands)
//   busy            at least one operation in flight
module mult_share_arb #(
  parameter int DW      = 1,
  parameter int NREQ    = 4,
  parameter int MUL_LAT = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  mult_share_arb_if.slave       bus,
  output logic [DW-1:0]         mul_i0,
  output logic [DW-1:0]         mul_i1,
  input  logic [2*DW-1:0]       mul_out,
  output logic                  busy
);

  localparam int              PW     = $clog2(NREQ);
  localparam int              PW1    = PW + 1;
  localparam int              NST    = MUL_LAT + 1;
  localparam logic [PW:0]     NREQ_W = PW1'(NREQ);

  // One-hot decode of a requester index.
  function automatic logic [NREQ-1:0] idx_to_onehot(input logic [PW-1:0] idx);
    return NREQ'(1) << idx;
  endfunction

  logic [PW-1:0]   ptr;
  logic [PW-1:0]   ptr_next;
  logic [PW:0]     ptr_inc;
  logic [NREQ-1:0] eligible;
  logic [NREQ-1:0] grant_oh;
  logic [PW-1:0]   grant_idx;
  logic            found;
  logic            handshake;
  logic [PW:0]     cand;
  logic [PW:0]     cand_w;
  logic [PW-1:0]   cand_idx;
  logic            pick;
  logic [DW-1:0]   a_sel;
  logic [DW-1:0]   b_sel;
  logic [NST-1:0]  tag_v;
  logic [PW-1:0]   tag_idx [NST];
  logic [NREQ-1:0] rsp_vec;
  logic [2*DW-1:0] rsp_hold;

  assign eligible = bus.req_valid & ~bus.req_mask;

  // Round-robin scan: first eligible index at or above ptr, wrapping.
  always_comb begin
    found     = 1'b0;
    grant_idx = {PW{1'b0}};
    cand      = {PW1{1'b0}};
    cand_w    = {PW1{1'b0}};
    cand_idx  = {PW{1'b0}};
    pick      = 1'b0;
    for (int off = 0; off < NREQ; off++) begin
      cand      = {1'b0, ptr} + PW1'(off);
      cand_w    = (cand >= NREQ_W) ? (cand - NREQ_W) : cand;
      cand_idx  = cand_w[PW-1:0];
      pick      = ~found & eligible[cand_idx];
      grant_idx = pick ? cand_idx : grant_idx;
      found     = found | pick;
    end
  end

  // Grant is suppressed during reset so nothing is accepted then.
  assign handshake     = found & ~rst;
  assign grant_oh      = handshake ? idx_to_onehot(grant_idx) : {NREQ{1'b0}};
  assign bus.req_ready = grant_oh;

  // Pointer moves to the slot just after the granted requester.
  assign ptr_inc  = {1'b0, grant_idx} + PW1'(1);
  assign ptr_next = (ptr_inc == NREQ_W) ? {PW{1'b0}} : ptr_inc[PW-1:0];

  // AND-OR operand mux driven by the one-hot grant.
  always_comb begin
    a_sel = {DW{1'b0}};
    b_sel = {DW{1'b0}};
    for (int i = 0; i < NREQ; i++) begin
      a_sel = a_sel | (bus.req_a[i*DW +: DW] & {DW{grant_oh[i]}});
      b_sel = b_sel | (bus.req_b[i*DW +: DW] & {DW{grant_oh[i]}});
    end
  end

  // Pointer, operand registers, tag pipeline and registered response/status.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr      <= {PW{1'b0}};
      mul_i0   <= {DW{1'b0}};
      mul_i1   <= {DW{1'b0}};
      tag_v    <= {NST{1'b0}};
      for (int j = 0; j < NST; j++) begin
        tag_idx[j] <= {PW{1'b0}};
      end
      rsp_vec  <= {NREQ{1'b0}};
      rsp_hold <= {(2*DW){1'b0}};
      busy     <= 1'b0;
    end else begin
      if (handshake) begin
        ptr    <= ptr_next;
        mul_i0 <= a_sel;
        mul_i1 <= b_sel;
      end
      // Stage 0 records every edge; invalid entries simply carry valid=0.
      tag_v[0]   <= handshake;
      tag_idx[0] <= grant_idx;
      for (int j = 1; j < NST; j++) begin
        tag_v[j]   <= tag_v[j-1];
        tag_idx[j] <= tag_idx[j-1];
      end
      // The last stage lines up with a valid mul_out for its operation.
      rsp_vec <= tag_v[NST-1] ? idx_to_onehot(tag_idx[NST-1]) : {NREQ{1'b0}};
      if (tag_v[NST-1]) begin
        rsp_hold <= mul_out;
      end
      busy <= |tag_v;
    end
  end

  assign bus.rsp_valid = rsp_vec;
  assign bus.rsp_data  = rsp_hold;

endmodule

// File: tb/tb_mult_share_arb.sv
module tb_mult_share_arb;
  localparam int LAT = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // DUT0: DW=4, NREQ=4
  mult_share_arb_if #(.DW(4), .NREQ(4)) bus0 ();
  logic [3:0] mul0_i0, mul0_i1;
  logic [7:0] mul0_out;
  logic       busy0;
  mult_share_arb #(.DW(4), .NREQ(4), .MUL_LAT(LAT)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0.slave),
    .mul_i0(mul0_i0), .mul_i1(mul0_i1), .mul_out(mul0_out), .busy(busy0));

  // DUT1: DW=1, NREQ=4
  mult_share_arb_if #(.DW(1), .NREQ(4)) bus1 ();
  logic       mul1_i0, mul1_i1;
  logic [1:0] mul1_out;
  logic       busy1;
  mult_share_arb #(.DW(1), .NREQ(4), .MUL_LAT(LAT)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1.slave),
    .mul_i0(mul1_i0), .mul_i1(mul1_i1), .mul_out(mul1_out), .busy(busy1));

  // Pipelined multipliers with LAT register stages.
  logic [7:0] mp0 [LAT];
  logic [1:0] mp1 [LAT];
  always @(posedge clk) begin
    mp0[0] <= 8'(mul0_i0) * 8'(mul0_i1);
    mp1[0] <= 2'(mul1_i0) * 2'(mul1_i1);
    for (int j = 1; j < LAT; j++) begin
      mp0[j] <= mp0[j-1];
      mp1[j] <= mp1[j-1];
    end
  end
  assign mul0_out = mp0[LAT-1];
  assign mul1_out = mp1[LAT-1];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model state: pointer, pending responses, last product, operands.
  typedef struct { int due; int idx; logic [7:0] prod; } pend_t;
  pend_t      q[$];
  int         ptr_m   = 0;
  int         edge_n  = 0;
  logic [7:0] last_rd = 8'd0;
  logic [3:0] mi0_m   = 4'd0;
  logic [3:0] mi1_m   = 4'd0;

  // Samples taken in the most recent tick.
  logic [3:0] s_rdy, s_rv, s_mi0, s_mi1, s_rv1;
  logic [7:0] s_rd;
  logic [1:0] s_rd1;
  logic       s_busy;

  function automatic int model_grant();
    int k;
    if (rst) return -1;
    for (int off = 0; off < 4; off++) begin
      k = (ptr_m + off) % 4;
      if (bus0.req_valid[k] && !bus0.req_mask[k]) return k;
    end
    return -1;
  endfunction

  // One clock: sample/check at negedge, advance model at posedge.
  task automatic tick();
    int         g;
    logic [3:0] exp_rv;
    logic       exp_busy;
    pend_t      e;
    @(negedge clk);
    s_rdy = bus0.req_ready; s_rv = bus0.rsp_valid; s_rd = bus0.rsp_data;
    s_busy = busy0; s_mi0 = mul0_i0; s_mi1 = mul0_i1;
    s_rv1 = bus1.rsp_valid; s_rd1 = bus1.rsp_data;
    g = model_grant();
    chk("req_ready", s_rdy, (g < 0) ? 4'b0000 : (4'b0001 << g));
    exp_busy = 1'b0;
    foreach (q[i]) if (q[i].due - LAT <= edge_n) exp_busy = 1'b1;
    exp_rv = 4'b0000;
    if (q.size() > 0 && q[0].due == edge_n) begin
      e = q.pop_front();
      exp_rv  = 4'b0001 << e.idx;
      last_rd = e.prod;
    end
    chk("rsp_valid", s_rv, exp_rv);
    chk("rsp_data", s_rd, last_rd);
    chk("busy", s_busy, exp_busy);
    chk("mul_i0", s_mi0, mi0_m);
    chk("mul_i1", s_mi1, mi1_m);
    @(posedge clk);
    edge_n++;
    if (rst) begin
      q.delete(); ptr_m = 0; last_rd = 8'd0; mi0_m = 4'd0; mi1_m = 4'd0;
    end else if (g >= 0) begin
      e.due  = edge_n + LAT + 1;
      e.idx  = g;
      mi0_m  = bus0.req_a[g*4 +: 4];
      mi1_m  = bus0.req_b[g*4 +: 4];
      e.prod = 8'(int'(mi0_m) * int'(mi1_m));
      q.push_back(e);
      ptr_m = (g + 1) % 4;
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  typedef struct { logic [3:0] valid; logic [3:0] mask; logic [3:0] exp_ready; } vec_t;
  vec_t tab [13];

  logic [3:0] exp_rv_b [9];
  logic [7:0] exp_rd_b [9];
  logic [1:0] ab;

  initial begin
    // Arbitration table, starting from ptr=0 after reset.
    tab[0]  = '{4'b0010, 4'b0000, 4'b0010};
    tab[1]  = '{4'b1001, 4'b0000, 4'b1000};
    tab[2]  = '{4'b1001, 4'b0000, 4'b0001};
    tab[3]  = '{4'b0011, 4'b0001, 4'b0010};
    tab[4]  = '{4'b0011, 4'b0001, 4'b0010};
    tab[5]  = '{4'b0011, 4'b0001, 4'b0010};
    tab[6]  = '{4'b0011, 4'b0000, 4'b0001};
    tab[7]  = '{4'b0011, 4'b0000, 4'b0010};
    tab[8]  = '{4'b0000, 4'b0000, 4'b0000};
    tab[9]  = '{4'b1111, 4'b1111, 4'b0000};
    tab[10] = '{4'b0100, 4'b0000, 4'b0100};
    tab[11] = '{4'b1111, 4'b0000, 4'b1000};
    tab[12] = '{4'b1111, 4'b0100, 4'b0001};
    exp_rv_b = '{4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0000};
    exp_rd_b = '{8'd0, 8'd0, 8'd0, 8'd2, 8'd6, 8'd12, 8'd20, 8'd2, 8'd0};

    bus0.req_valid = 4'b0; bus0.req_mask = 4'b0; bus0.req_a = 16'd0; bus0.req_b = 16'd0;
    bus1.req_valid = 4'b0; bus1.req_mask = 4'b0; bus1.req_a = 4'd0;  bus1.req_b = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();
    chk("reset_rsp_data", s_rd, 8'd0);

    // Requester 2 alone: 3 x 5.
    bus0.req_valid = 4'b0100; bus0.req_a = 16'h0300; bus0.req_b = 16'h0500;
    tick(); chk("single_ready", s_rdy, 4'b0100);
    bus0.req_valid = 4'b0000;
    tick(); chk("single_busy_k", s_busy, 1'b0); chk("single_mi0", s_mi0, 4'd3);
    tick(); chk("single_busy_k1", s_busy, 1'b1); chk("single_rv_k1", s_rv, 4'b0000);
    tick(); chk("single_rv_k2", s_rv, 4'b0100); chk("single_rd_k2", s_rd, 8'd15);
            chk("single_busy_k2", s_busy, 1'b1);
    tick(); chk("single_rv_k3", s_rv, 4'b0000); chk("single_busy_k3", s_busy, 1'b0);
            chk("single_hold_k3", s_rd, 8'd15);

    // All four continuously valid: rotation and back-to-back responses.
    do_reset();
    bus0.req_valid = 4'b1111; bus0.req_a = 16'h4321; bus0.req_b = 16'h5432;
    for (int j = 0; j < 9; j++) begin
      if (j == 5) bus0.req_valid = 4'b0000;
      tick();
      if (j < 5) chk("rr_grant", s_rdy, 4'b0001 << (j % 4));
      chk("rr_rsp_valid", s_rv, exp_rv_b[j]);
      if (j >= 3 && j <= 7) chk("rr_rsp_data", s_rd, exp_rd_b[j]);
    end

    // Table-driven arbitration, pointer continuity and masking.
    do_reset();
    for (int i = 0; i < 13; i++) begin
      bus0.req_valid = tab[i].valid; bus0.req_mask = tab[i].mask;
      bus0.req_a = 16'($urandom); bus0.req_b = 16'($urandom);
      tick();
      chk($sformatf("table_%0d", i), s_rdy, tab[i].exp_ready);
    end
    bus0.req_valid = 4'b0000; bus0.req_mask = 4'b0000;
    repeat (3) tick();

    // Reset mid-flight: 7 x 9 discarded.
    do_reset();
    bus0.req_valid = 4'b0001; bus0.req_a = 16'h0007; bus0.req_b = 16'h0009;
    tick();
    rst = 1'b1;
    tick(); chk("rst_ready_zero", s_rdy, 4'b0000);
    rst = 1'b0; bus0.req_valid = 4'b0000;
    tick();
    chk("rst_rd", s_rd, 8'd0); chk("rst_busy", s_busy, 1'b0);
    chk("rst_mi0", s_mi0, 4'd0); chk("rst_mi1", s_mi1, 4'd0);
    for (int j = 0; j < 3; j++) begin
      tick(); chk("rst_no_rsp", s_rv, 4'b0000);
    end

    // DW=1 exhaustive on the second instance.
    for (int c = 0; c < 4; c++) begin
      ab = 2'(c);
      bus1.req_valid = 4'b0001; bus1.req_a = {3'b000, ab[1]}; bus1.req_b = {3'b000, ab[0]};
      tick();
      bus1.req_valid = 4'b0000;
      repeat (3) tick();
      chk("dw1_rv", s_rv1, 4'b0001);
      chk("dw1_rd", s_rd1, (ab == 2'b11) ? 2'b01 : 2'b00);
    end

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 39) == 0);
      bus0.req_valid = 4'($urandom);
      bus0.req_mask  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
      bus0.req_a = 16'($urandom); bus0.req_b = 16'($urandom);
      tick();
    end
    rst = 1'b0; bus0.req_valid = 4'b0000;
    repeat (4) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
